wb_bram_reader: RTL and testbench
=================================

WB_BRAM_READER -- requirements
Module: wb_bram_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address width of target memory.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles waiting for ack (used only with REQ-029 macro).
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_start  in  1  one-cycle request to begin a transfer.
REQ-006 SHALL have port i_base_adr  in  ADDR_WIDTH  first word address.
REQ-007 SHALL have port i_count  in  ADDR_WIDTH+1  number of words to read.
REQ-008 SHALL have port o_busy  out  1  high from accepted start until DONE exits.
REQ-009 SHALL have port o_done  out  1  one-cycle completion pulse.
REQ-010 SHALL have port o_error  out  1  sticky timeout flag.
REQ-011 SHALL have ports o_wbm_cyc, o_wbm_stb, o_wbm_we  out  1 each  Wishbone master controls.
REQ-012 SHALL have ports o_wbm_sel  out  4, o_wbm_adr  out  32, o_wbm_dat  out  32  Wishbone master outputs.
REQ-013 SHALL have ports i_wbm_dat  in  32, i_wbm_ack  in  1  Wishbone slave response.
REQ-014 SHALL have ports o_data  out  32, o_valid  out  1, i_ready  in  1  downstream stream.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, RELEASE, PUSH, DONE.
REQ-016 IDLE: i_start=1 SHALL latch i_base_adr/i_count, set o_busy, go REQ (DONE if i_count=0, no bus traffic).
REQ-017 i_start while o_busy=1 SHALL be ignored.
REQ-018 o_wbm_cyc SHALL be high from REQ entry of first word until leaving RELEASE of last word.
REQ-019 REQ: o_wbm_stb=1, o_wbm_adr={18'b0? no: zero-extended (base+index) mod 2^ADDR_WIDTH, 2'b00}, i.e. byte address = word address shifted left 2, upper bits zero.
REQ-020 Word address SHALL wrap modulo 2^ADDR_WIDTH (base 1023, count 2 at default -> words 1023, 0).
REQ-021 REQ: on i_wbm_ack=1 SHALL capture i_wbm_dat into o_data, drop o_wbm_stb next cycle, go RELEASE.
REQ-022 RELEASE: stb low; SHALL wait until i_wbm_ack=0, then go PUSH with o_valid=1.
REQ-023 PUSH: o_valid and o_data SHALL hold stable until i_ready=1; on o_valid&i_ready, clear o_valid, decrement remaining; remaining>0 -> REQ (index+1), else DONE.
REQ-024 At most one word in flight; no new stb while o_valid=1.
REQ-025 DONE: o_done=1 one cycle, o_busy=0 and o_wbm_cyc=0 next cycle, return IDLE.
REQ-026 o_wbm_we SHALL be constant 0, o_wbm_sel constant 4'hF, o_wbm_dat constant 0.
REQ-027 o_error SHALL clear on accepted i_start; otherwise hold.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE and o_busy, o_done, o_error, o_wbm_cyc, o_wbm_stb, o_valid = 0, o_wbm_adr = 0, o_data = 0, counters = 0; assertion mid-transfer aborts with no o_done pulse.

Configuration
REQ-029 With WB_READER_TIMEOUT_EN defined: a counter SHALL run in REQ; TIMEOUT_CYCLES cycles without ack SHALL drop cyc/stb, set o_error=1, go DONE (o_done pulses, no o_valid for that word).
REQ-030 Without WB_READER_TIMEOUT_EN: REQ SHALL wait indefinitely, o_error SHALL be constant 0, no timeout counter synthesized.

Verification
REQ-031 Slave with 5-cycle ack latency, base=0x004, count=3, i_ready=1 -> adr 0x10,0x14,0x18 in order, three o_valid beats with memory data, one o_done, o_busy low after.
REQ-032 count=0 -> o_done one cycle after start, o_wbm_cyc never asserted.
REQ-033 base=0x3FF, count=2 -> adr 0xFFC then 0x000.
REQ-034 i_ready held low 10 cycles on first word -> o_data stable, no stb for word 2 until beat accepted.
REQ-035 Macro defined, slave never acks -> after 255 cycles stb/cyc drop, o_error=1, o_done pulses; next start clears o_error.
REQ-036 rst_n low mid-REQ -> all outputs 0 immediately (async), no o_done; new start after release works normally.

Source files
------------

// File: rtl/wb_bram_reader.sv
// Purpose : Wishbone classic master that reads a block of words from a BRAM-style
//           slave and forwards them one at a time on a valid/ready stream.
// Latency : one Wishbone cycle per word plus RELEASE and PUSH states; o_done one cycle after the last beat.
// Backpressure: a single word is buffered in o_data; no new strobe is issued until
//               the current beat is taken by i_ready.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_start/i_base_adr/i_count transfer request (ignored while o_busy)
//   o_busy, o_done, o_error    status (o_error sticky, cleared by next accepted start)
//   o_wbm_*/i_wbm_*            Wishbone master port (read-only, byte address = word << 2)
//   o_data/o_valid/i_ready     downstream stream
//
// Optional feature: define WB_READER_TIMEOUT_EN to abort a word that is not
// acknowledged within TIMEOUT_CYCLES cycles and raise o_error.

module wb_bram_reader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_adr,
    input  logic [ADDR_WIDTH:0]   i_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic                  o_wbm_cyc,
    output logic                  o_wbm_stb,
    output logic                  o_wbm_we,
    output logic [3:0]            o_wbm_sel,
    output logic [31:0]           o_wbm_adr,
    output logic [31:0]           o_wbm_dat,
    input  logic [31:0]           i_wbm_dat,
    input  logic                  i_wbm_ack,
    output logic [31:0]           o_data,
    output logic                  o_valid,
    input  logic                  i_ready
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RELEASE,
        PUSH,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] adr_word;   // current word address, wraps naturally
    logic [ADDR_WIDTH:0]   remaining;  // words still to be pushed, including current

    // Read-only master: these never change.
    assign o_wbm_we  = 1'b0;
    assign o_wbm_sel = 4'hF;
    assign o_wbm_dat = 32'h0;
    assign o_wbm_adr = {{(30 - ADDR_WIDTH){1'b0}}, adr_word, 2'b00};

    wire last_word = (remaining == (ADDR_WIDTH + 1)'(1));

`ifdef WB_READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          error_q;
    assign o_error = error_q;
`else
    assign o_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            adr_word  <= '0;
            remaining <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_wbm_cyc <= 1'b0;
            o_wbm_stb <= 1'b0;
            o_data    <= 32'h0;
            o_valid   <= 1'b0;
`ifdef WB_READER_TIMEOUT_EN
            tmo_cnt   <= '0;
            error_q   <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_busy    <= 1'b1;
                        adr_word  <= i_base_adr;
                        remaining <= i_count;
`ifdef WB_READER_TIMEOUT_EN
                        error_q   <= 1'b0;
                        tmo_cnt   <= '0;
`endif
                        if (i_count == '0) begin
                            // Empty request: complete without touching the bus.
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            o_wbm_cyc <= 1'b1;
                            o_wbm_stb <= 1'b1;
                            state     <= REQ;
                        end
                    end
                end

                REQ: begin
                    if (i_wbm_ack) begin
                        o_data    <= i_wbm_dat;
                        o_wbm_stb <= 1'b0;
                        state     <= RELEASE;
                    end
`ifdef WB_READER_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        // Slave never answered: abandon the block, no beat for this word.
                        o_wbm_cyc <= 1'b0;
                        o_wbm_stb <= 1'b0;
                        error_q   <= 1'b1;
                        o_done    <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                RELEASE: begin
                    // Wait for the slave to deassert ack before the next strobe can follow.
                    if (!i_wbm_ack) begin
                        o_valid <= 1'b1;
                        state   <= PUSH;
                        if (last_word) begin
                            o_wbm_cyc <= 1'b0;
                        end
                    end
                end

                PUSH: begin
                    if (i_ready) begin
                        o_valid   <= 1'b0;
                        remaining <= remaining - 1'b1;
                        if (last_word) begin
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            adr_word  <= adr_word + 1'b1;
                            o_wbm_cyc <= 1'b1;
                            o_wbm_stb <= 1'b1;
`ifdef WB_READER_TIMEOUT_EN
                            tmo_cnt   <= '0;
`endif
                            state     <= REQ;
                        end
                    end
                end

                DONE: begin
                    o_busy    <= 1'b0;
                    o_wbm_cyc <= 1'b0;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bram_reader.sv
// Purpose : directed self-checking bench for wb_bram_reader with a behavioural
//           Wishbone slave (fixed ack latency, data = 0xA5000000 | word address).
// Latency/backpressure are exercised through i_ready stalls and the slave latency.

module tb_wb_bram_reader;

    localparam int AW  = 10;
    localparam int LAT = 5;

    logic          clk;
    logic          rst_n;
    logic          i_start;
    logic [AW-1:0] i_base_adr;
    logic [AW:0]   i_count;
    logic          o_busy, o_done, o_error;
    logic          o_wbm_cyc, o_wbm_stb, o_wbm_we;
    logic [3:0]    o_wbm_sel;
    logic [31:0]   o_wbm_adr, o_wbm_dat;
    logic [31:0]   i_wbm_dat;
    logic          i_wbm_ack;
    logic [31:0]   o_data;
    logic          o_valid;
    logic          i_ready;

    wb_bram_reader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(255)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_base_adr (i_base_adr),
        .i_count    (i_count),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_error    (o_error),
        .o_wbm_cyc  (o_wbm_cyc),
        .o_wbm_stb  (o_wbm_stb),
        .o_wbm_we   (o_wbm_we),
        .o_wbm_sel  (o_wbm_sel),
        .o_wbm_adr  (o_wbm_adr),
        .o_wbm_dat  (o_wbm_dat),
        .i_wbm_dat  (i_wbm_dat),
        .i_wbm_ack  (i_wbm_ack),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slave: ack LAT cycles after strobe, hold ack until strobe drops.
    logic no_ack;
    int   lat;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_wbm_ack <= 1'b0;
            i_wbm_dat <= 32'h0;
            lat       <= 0;
        end else if (o_wbm_cyc && o_wbm_stb && !i_wbm_ack) begin
            if (no_ack) begin
                lat <= 0;
            end else if (lat == LAT - 1) begin
                i_wbm_ack <= 1'b1;
                i_wbm_dat <= 32'hA500_0000 | {22'h0, o_wbm_adr[11:2]};
                lat       <= 0;
            end else begin
                lat <= lat + 1;
            end
        end else if (!o_wbm_stb) begin
            i_wbm_ack <= 1'b0;
            lat       <= 0;
        end
    end

    // Bus / stream monitor, sampled on the falling edge.
    logic [31:0] adr_q[$];
    logic [31:0] dat_q[$];
    int cyc_cnt, stb_cycles, stb_while_valid, done_cnt, beat_cnt;
    initial begin
        cyc_cnt = 0; stb_cycles = 0; stb_while_valid = 0; done_cnt = 0; beat_cnt = 0;
    end
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_wbm_cyc) cyc_cnt++;
            if (o_wbm_stb) stb_cycles++;
            if (o_wbm_stb && i_wbm_ack) adr_q.push_back(o_wbm_adr);
            if (o_valid && i_ready) begin
                dat_q.push_back(o_data);
                beat_cnt++;
            end
            if (o_done) done_cnt++;
            if (o_wbm_stb && o_valid) stb_while_valid++;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [AW-1:0] base, input logic [AW:0] cnt);
        @(posedge clk); #1;
        i_start    = 1'b1;
        i_base_adr = base;
        i_count    = cnt;
        @(posedge clk); #1;
        i_start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!o_done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, {31'h0, o_done}, 32'h1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!o_valid && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, {31'h0, o_valid}, 32'h1);
    endtask

    int a0, d0, c0, dn0, s0, b0, bad;
    logic [31:0] hold_dat;

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_base_adr = '0; i_count = '0; i_ready = 1'b1; no_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_busy",  {31'h0, o_busy},    32'h0);
        check("rst_done",  {31'h0, o_done},    32'h0);
        check("rst_error", {31'h0, o_error},   32'h0);
        check("rst_cyc",   {31'h0, o_wbm_cyc}, 32'h0);
        check("rst_stb",   {31'h0, o_wbm_stb}, 32'h0);
        check("rst_valid", {31'h0, o_valid},   32'h0);
        check("rst_adr",   o_wbm_adr,          32'h0);
        check("rst_data",  o_data,             32'h0);
        check("const_we",  {31'h0, o_wbm_we},  32'h0);
        check("const_sel", {28'h0, o_wbm_sel}, 32'hF);
        check("const_dat", o_wbm_dat,          32'h0);
        rst_n = 1'b1;

        // Three words from word 4, no backpressure
        a0 = adr_q.size(); d0 = dat_q.size(); dn0 = done_cnt;
        do_start(10'h004, 11'd3);
        check("t1_busy", {31'h0, o_busy}, 32'h1);
        wait_done("t1_done", 200);
        @(posedge clk); #1;
        check("t1_busy_after", {31'h0, o_busy},    32'h0);
        check("t1_cyc_after",  {31'h0, o_wbm_cyc}, 32'h0);
        check("t1_nadr", adr_q.size() - a0, 32'd3);
        check("t1_adr0", adr_q[a0],     32'h10);
        check("t1_adr1", adr_q[a0 + 1], 32'h14);
        check("t1_adr2", adr_q[a0 + 2], 32'h18);
        check("t1_nbeat", dat_q.size() - d0, 32'd3);
        check("t1_dat0", dat_q[d0],     32'hA500_0004);
        check("t1_dat1", dat_q[d0 + 1], 32'hA500_0005);
        check("t1_dat2", dat_q[d0 + 2], 32'hA500_0006);
        check("t1_ndone", done_cnt - dn0, 32'd1);

        // Empty request: done one cycle after start, bus untouched
        c0 = cyc_cnt; dn0 = done_cnt;
        do_start(10'h000, 11'd0);
        check("t2_done_pulse", {31'h0, o_done}, 32'h1);
        @(posedge clk); #1;
        check("t2_done_low", {31'h0, o_done}, 32'h0);
        check("t2_busy_low", {31'h0, o_busy}, 32'h0);
        check("t2_no_cyc", cyc_cnt - c0, 32'd0);
        check("t2_ndone", done_cnt - dn0, 32'd1);

        // Address wrap at the top of the word space
        a0 = adr_q.size(); d0 = dat_q.size();
        do_start(10'h3FF, 11'd2);
        wait_done("t3_done", 200);
        check("t3_adr0", adr_q[a0],     32'hFFC);
        check("t3_adr1", adr_q[a0 + 1], 32'h000);
        check("t3_dat0", dat_q[d0],     32'hA500_03FF);
        check("t3_dat1", dat_q[d0 + 1], 32'hA500_0000);

        // Downstream stall on the first word; a second start while busy is ignored
        a0 = adr_q.size(); d0 = dat_q.size(); s0 = stb_while_valid;
        i_ready = 1'b0;
        do_start(10'h008, 11'd2);
        wait_valid("t4_valid", 100);
        hold_dat = o_data;
        check("t4_hold_dat", hold_dat, 32'hA500_0008);
        @(posedge clk); #1;
        i_start = 1'b1; i_base_adr = 10'h100; i_count = 11'd5;
        @(posedge clk); #1;
        i_start = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!o_valid || o_data !== hold_dat || o_wbm_stb) bad++;
            @(posedge clk); #1;
        end
        check("t4_stall_stable", bad, 32'd0);
        i_ready = 1'b1;
        wait_done("t4_done", 200);
        @(posedge clk); #1;
        check("t4_nadr", adr_q.size() - a0, 32'd2);
        check("t4_adr1", adr_q[a0 + 1], 32'h24);
        check("t4_dat1", dat_q[d0 + 1], 32'hA500_0009);
        check("t4_stb_vs_valid", stb_while_valid - s0, 32'd0);
        check("t4_error", {31'h0, o_error}, 32'h0);

`ifdef WB_READER_TIMEOUT_EN
        // Slave never answers: timeout aborts the block
        s0 = stb_cycles; b0 = beat_cnt; dn0 = done_cnt;
        no_ack = 1'b1;
        do_start(10'h000, 11'd1);
        wait_done("t5_done", 400);
        check("t5_error", {31'h0, o_error},   32'h1);
        check("t5_cyc",   {31'h0, o_wbm_cyc}, 32'h0);
        check("t5_stb",   {31'h0, o_wbm_stb}, 32'h0);
        @(posedge clk); #1;
        check("t5_stb_cycles", stb_cycles - s0, 32'd255);
        check("t5_no_beat", beat_cnt - b0, 32'd0);
        check("t5_ndone", done_cnt - dn0, 32'd1);
        check("t5_error_hold", {31'h0, o_error}, 32'h1);
        no_ack = 1'b0;
        do_start(10'h000, 11'd0);
        check("t5_error_clr", {31'h0, o_error}, 32'h0);
        @(posedge clk); #1;
`endif

        // Asynchronous reset while a word is being requested
        dn0 = done_cnt;
        do_start(10'h000, 11'd2);
        @(posedge clk); #1;
        check("t6_stb_pre", {31'h0, o_wbm_stb}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_cyc",  {31'h0, o_wbm_cyc}, 32'h0);
        check("t6_stb",  {31'h0, o_wbm_stb}, 32'h0);
        check("t6_busy", {31'h0, o_busy},    32'h0);
        check("t6_adr",  o_wbm_adr,          32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_done", done_cnt - dn0, 32'd0);
        a0 = adr_q.size(); d0 = dat_q.size();
        do_start(10'h010, 11'd1);
        wait_done("t6_done", 200);
        check("t6_adr_after", adr_q[a0], 32'h40);
        check("t6_dat_after", dat_q[d0], 32'hA500_0010);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
